// File: rtl/cmsdk_ahb_qos_arbiter.sv
// QoS output-stage arbiter for one bus-matrix slave port.
// Picks which of four input ports owns the address phase, using per-port
// priority, round-robin tie-break and starvation counters, while never
// breaking a fixed-length burst or a locked sequence.
module cmsdk_ahb_qos_arbiter #(
    parameter int STARVE_LIMIT = 15
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] req,
    input  logic [7:0] prio_cfg,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic [3:0] urgent
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [1:0] addr_reg, addr_next;
    logic       no_port_reg, no_port_next;
    logic [3:0] urgent_reg, urgent_next;
    logic [3:0] remain_reg, remain_next;
    logic       hold_reg, hold_next;
    logic [3:0] wait_reg  [4];
    logic [3:0] wait_next [4];

    logic [1:0] port_prio [4];
    logic [1:0] max_prio;
    logic [3:0] prio_match;
    logic [3:0] compete;
    logic [1:0] scan_start;
    logic [1:0] pick;
    logic       pick_found;
    logic       freeze;

    assign addr_in_port = addr_reg;
    assign no_port      = no_port_reg;
    assign urgent       = urgent_reg;

    // Burst beat tracker: remaining SEQ beats and whether the grant is pinned
    always_comb begin
        remain_next = remain_reg;
        hold_next   = hold_reg;
        if (!HSELM || HTRANSM == TRANS_IDLE) begin
            remain_next = 4'd0;
            hold_next   = 1'b0;
        end else if (HTRANSM == TRANS_NONSEQ) begin
            case (HBURSTM)
                3'b010, 3'b011: begin remain_next = 4'd3;  hold_next = 1'b1; end
                3'b100, 3'b101: begin remain_next = 4'd7;  hold_next = 1'b1; end
                3'b110, 3'b111: begin remain_next = 4'd15; hold_next = 1'b1; end
                default:        begin remain_next = 4'd0;  hold_next = 1'b0; end
            endcase
        end else if (HTRANSM == TRANS_SEQ) begin
            if (remain_reg == 4'd0) begin
                hold_next = 1'b0;
            end else begin
                remain_next = remain_reg - 4'd1;
                // The final beat of a burst releases the grant on its own edge
                if (remain_reg == 4'd1) begin
                    hold_next = 1'b0;
                end
            end
        end
        // BUSY leaves the tracker untouched
    end

    assign freeze = HMASTLOCKM || hold_next;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prio
            assign port_prio[gi]  = prio_cfg[2*gi +: 2];
            assign prio_match[gi] = req[gi] && (port_prio[gi] == max_prio);
        end
    endgenerate

    // Highest priority level among the current requesters
    always_comb begin
        max_prio = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (port_prio[i] > max_prio)) begin
                max_prio = port_prio[i];
            end
        end
    end

    // Urgent requesters pre-empt the priority levels entirely
    assign compete    = (|(req & urgent_reg)) ? (req & urgent_reg) : prio_match;
    assign scan_start = no_port_reg ? 2'd0 : 2'(addr_reg + 2'd1);

    // Round-robin scan of the competing set starting after the current owner
    always_comb begin
        pick       = 2'd0;
        pick_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!pick_found && compete[2'(scan_start + 2'(k))]) begin
                pick       = 2'(scan_start + 2'(k));
                pick_found = 1'b1;
            end
        end
    end

    // Grant decision; with no requester the current owner stays parked if selected
    always_comb begin
        addr_next    = addr_reg;
        no_port_next = no_port_reg;
        if (!freeze) begin
            if (pick_found) begin
                addr_next    = pick;
                no_port_next = 1'b0;
            end else if (no_port_reg || !HSELM) begin
                no_port_next = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wait
            // Starvation counter: cleared when idle or granted, else saturating count
            always_comb begin
                if (!req[gi] || (!no_port_next && addr_next == 2'(gi))) begin
                    wait_next[gi] = 4'd0;
                end else if (wait_reg[gi] >= LIMIT) begin
                    wait_next[gi] = LIMIT;
                end else begin
                    wait_next[gi] = wait_reg[gi] + 4'd1;
                end
                urgent_next[gi] = (wait_next[gi] == LIMIT);
            end
        end
    endgenerate

    // State registers; reset wins over the HREADYM qualifier
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_reg    <= 2'd0;
            no_port_reg <= 1'b1;
            urgent_reg  <= 4'd0;
            remain_reg  <= 4'd0;
            hold_reg    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wait_reg[i] <= 4'd0;
            end
        end else if (HREADYM) begin
            addr_reg    <= addr_next;
            no_port_reg <= no_port_next;
            urgent_reg  <= urgent_next;
            remain_reg  <= remain_next;
            hold_reg    <= hold_next;
            for (int i = 0; i < 4; i++) begin
                wait_reg[i] <= wait_next[i];
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_qos_arbiter.sv
// Self-checking bench for cmsdk_ahb_qos_arbiter: directed scenarios from the
// feature list plus randomized traffic, all checked against a behavioural model.
module tb_cmsdk_ahb_qos_arbiter;

    localparam int LIMIT = 3;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req;
    logic [7:0] prio_cfg;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic [3:0] urgent;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    // Behavioural model state
    int         m_addr;
    int         m_nop;
    int         m_wait [4];
    int         m_rem;
    int         m_hold;
    logic [3:0] m_urg;

    cmsdk_ahb_qos_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .req(req),
        .prio_cfg(prio_cfg),
        .HREADYM(HREADYM),
        .HSELM(HSELM),
        .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_in_port),
        .no_port(no_port),
        .urgent(urgent)
    );

    always #5 HCLK = ~HCLK;

    // Model of one rising edge, computed from the rules with plain integers
    task automatic model_step();
        int  nrem;
        int  nhold;
        int  naddr;
        int  nnop;
        int  nreq;
        int  any_urg;
        int  maxp;
        int  first;
        int  p;
        bit  chosen;
        bit  eligible [4];
        if (HRESET) begin
            m_addr = 0; m_nop = 1; m_rem = 0; m_hold = 0; m_urg = 4'b0000;
            for (int i = 0; i < 4; i++) m_wait[i] = 0;
            return;
        end
        if (!HREADYM) return;
        nrem = m_rem;
        nhold = m_hold;
        if (!HSELM || HTRANSM == 2'b00) begin
            nrem = 0; nhold = 0;
        end else if (HTRANSM == 2'b10) begin
            case (int'(HBURSTM))
                2, 3:    begin nrem = 3;  nhold = 1; end
                4, 5:    begin nrem = 7;  nhold = 1; end
                6, 7:    begin nrem = 15; nhold = 1; end
                default: begin nrem = 0;  nhold = 0; end
            endcase
        end else if (HTRANSM == 2'b11) begin
            if (m_rem == 0) nhold = 0;
            else begin
                nrem = m_rem - 1;
                if (nrem == 0) nhold = 0;
            end
        end
        naddr = m_addr;
        nnop = m_nop;
        if (!(HMASTLOCKM || nhold != 0)) begin
            nreq = 0; any_urg = 0; maxp = -1;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    nreq++;
                    if (m_urg[i]) any_urg = 1;
                    if (int'(prio_cfg[2*i +: 2]) > maxp) maxp = int'(prio_cfg[2*i +: 2]);
                end
            end
            for (int i = 0; i < 4; i++)
                eligible[i] = req[i] && (any_urg != 0 ? m_urg[i] == 1'b1
                                                      : int'(prio_cfg[2*i +: 2]) == maxp);
            if (nreq > 0) begin
                first = (m_nop != 0) ? 0 : (m_addr + 1) % 4;
                chosen = 0;
                for (int k = 0; k < 4; k++) begin
                    p = (first + k) % 4;
                    if (!chosen && eligible[p]) begin
                        naddr = p; nnop = 0; chosen = 1;
                    end
                end
            end else if (m_nop != 0 || !HSELM) begin
                nnop = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!req[i] || (nnop == 0 && naddr == i)) m_wait[i] = 0;
            else m_wait[i] = (m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1;
            m_urg[i] = (m_wait[i] == LIMIT);
        end
        m_addr = naddr; m_nop = nnop; m_rem = nrem; m_hold = nhold;
    endtask

    // Advance model and DUT by one clock; outputs sampled 1 ns after the edge
    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
        cycle++;
        $display("[TB] cyc %0d rst=%b rdy=%b req=%b trans=%b burst=%b lock=%b -> addr=%0d no_port=%b urgent=%b",
                 cycle, HRESET, HREADYM, req, HTRANSM, HBURSTM, HMASTLOCKM,
                 addr_in_port, no_port, urgent);
    endtask

    task automatic idle_inputs();
        HRESET = 1'b0; req = 4'b0000; prio_cfg = 8'h00; HREADYM = 1'b1;
        HSELM = 1'b0; HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1'b1;
        HREADYM = 1'b0;
        tick();
        tick();
        tests_run++;
        if (addr_in_port !== 2'd0 || no_port !== 1'b1 || urgent !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset: addr=%0d no_port=%b urgent=%b, expected addr=0 no_port=1 urgent=0000",
                     addr_in_port, no_port, urgent);
        end
        HRESET = 1'b0;
        HREADYM = 1'b1;
    endtask

    task automatic test_grant_release();
        req = 4'b0100;
        tick();
        tests_run++;
        if (addr_in_port !== 2'd2 || no_port !== 1'b0) begin
            tests_failed++;
            $display("FAIL grant_single: addr=%0d no_port=%b, expected addr=2 no_port=0",
                     addr_in_port, no_port);
        end
        req = 4'b0000;
        HSELM = 1'b0;
        tick();
        tests_run++;
        if (addr_in_port !== 2'd2 || no_port !== 1'b1) begin
            tests_failed++;
            $display("FAIL release: addr=%0d no_port=%b, expected addr=2 no_port=1",
                     addr_in_port, no_port);
        end
    endtask

    task automatic test_burst();
        do_reset();
        req = 4'b0001; HSELM = 1'b1; HTRANSM = 2'b00;
        tick();
        req = 4'b1110; HTRANSM = 2'b10; HBURSTM = 3'b101;
        for (int beat = 1; beat <= 8; beat++) begin
            if (beat > 1) HTRANSM = 2'b11;
            tick();
            tests_run++;
            if (addr_in_port !== ((beat == 8) ? 2'd1 : 2'd0) || no_port !== 1'b0) begin
                tests_failed++;
                $display("FAIL burst beat %0d: addr=%0d no_port=%b, expected addr=%0d no_port=0",
                         beat, addr_in_port, no_port, (beat == 8) ? 1 : 0);
            end
        end
        HTRANSM = 2'b00;
        tick();
        tests_run++;
        if (addr_in_port !== 2'(m_addr) || no_port !== m_nop[0] || urgent !== m_urg) begin
            tests_failed++;
            $display("FAIL burst_after: addr=%0d no_port=%b urgent=%b, expected addr=%0d no_port=%0d urgent=%b",
                     addr_in_port, no_port, urgent, m_addr, m_nop, m_urg);
        end
    endtask

    task automatic test_priority_starve();
        int exp_port [7];
        exp_port = '{3, 3, 3, 0, 1, 2, 3};
        do_reset();
        prio_cfg = 8'b11_00_00_00; req = 4'b1111; HSELM = 1'b1;
        HTRANSM = 2'b10; HBURSTM = 3'b000;
        for (int n = 0; n < 7; n++) begin
            tick();
            tests_run++;
            if (addr_in_port !== 2'(exp_port[n]) || no_port !== 1'b0 || urgent !== m_urg) begin
                tests_failed++;
                $display("FAIL prio grant %0d: addr=%0d no_port=%b urgent=%b, expected addr=%0d no_port=0 urgent=%b",
                         n, addr_in_port, no_port, urgent, exp_port[n], m_urg);
            end
            if (n == 2) begin
                tests_run++;
                if (urgent !== 4'b0111) begin
                    tests_failed++;
                    $display("FAIL prio urgent: urgent=%b, expected 0111", urgent);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        req = 4'b0010; HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b000;
        tick();
        HMASTLOCKM = 1'b1;
        req = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            tick();
            tests_run++;
            if (addr_in_port !== 2'd1 || no_port !== 1'b0 || urgent[0] !== (n >= LIMIT)) begin
                tests_failed++;
                $display("FAIL lock cycle %0d: addr=%0d no_port=%b urgent=%b, expected addr=1 no_port=0 urgent[0]=%0d",
                         n, addr_in_port, no_port, urgent, (n >= LIMIT));
            end
        end
        HMASTLOCKM = 1'b0;
        tick();
        tests_run++;
        if (addr_in_port !== 2'd0 || no_port !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_release: addr=%0d no_port=%b, expected addr=0 no_port=0",
                     addr_in_port, no_port);
        end
    endtask

    task automatic test_hready_and_reset();
        logic [1:0] s_addr;
        logic       s_nop;
        logic [3:0] s_urg;
        req = 4'b0110; HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b000;
        tick();
        tick();
        s_addr = addr_in_port; s_nop = no_port; s_urg = urgent;
        HREADYM = 1'b0;
        for (int n = 0; n < 4; n++) begin
            req = 4'($urandom);
            tick();
            tests_run++;
            if (addr_in_port !== s_addr || no_port !== s_nop || urgent !== s_urg) begin
                tests_failed++;
                $display("FAIL hready_hold %0d: addr=%0d no_port=%b urgent=%b, expected addr=%0d no_port=%b urgent=%b",
                         n, addr_in_port, no_port, urgent, s_addr, s_nop, s_urg);
            end
        end
        HREADYM = 1'b1;
        req = 4'b0011;
        tick();
        tests_run++;
        if (addr_in_port !== 2'(m_addr) || no_port !== m_nop[0] || urgent !== m_urg) begin
            tests_failed++;
            $display("FAIL hready_resume: addr=%0d no_port=%b urgent=%b, expected addr=%0d no_port=%0d urgent=%b",
                     addr_in_port, no_port, urgent, m_addr, m_nop, m_urg);
        end
        // Park on port 0, start an INCR16 and reset it with remain at 9
        req = 4'b0001; HTRANSM = 2'b00;
        tick();
        req = 4'b1111; HTRANSM = 2'b10; HBURSTM = 3'b111;
        tick();
        HTRANSM = 2'b11;
        for (int n = 0; n < 6; n++) tick();
        tests_run++;
        if (addr_in_port !== 2'd0 || no_port !== 1'b0 || urgent !== 4'b1110) begin
            tests_failed++;
            $display("FAIL incr16_hold: addr=%0d no_port=%b urgent=%b, expected addr=0 no_port=0 urgent=1110",
                     addr_in_port, no_port, urgent);
        end
        HRESET = 1'b1;
        HREADYM = 1'b0;
        tick();
        tests_run++;
        if (addr_in_port !== 2'd0 || no_port !== 1'b1 || urgent !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_burst: addr=%0d no_port=%b urgent=%b, expected addr=0 no_port=1 urgent=0000",
                     addr_in_port, no_port, urgent);
        end
        HRESET = 1'b0;
        HREADYM = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            HRESET     = ($urandom_range(0, 63) == 0);
            HREADYM    = ($urandom_range(0, 3) != 0);
            req        = 4'($urandom);
            HSELM      = ($urandom_range(0, 7) != 0);
            HTRANSM    = 2'($urandom);
            HBURSTM    = 3'($urandom);
            HMASTLOCKM = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) prio_cfg = 8'($urandom);
            tick();
            tests_run++;
            if (addr_in_port !== 2'(m_addr) || no_port !== m_nop[0] || urgent !== m_urg) begin
                tests_failed++;
                $display("FAIL random cyc %0d: addr=%0d no_port=%b urgent=%b, expected addr=%0d no_port=%0d urgent=%b",
                         cycle, addr_in_port, no_port, urgent, m_addr, m_nop, m_urg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_grant_release();
        test_burst();
        test_priority_starve();
        test_lock();
        test_hready_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
